// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_DEFAULT = 2;
endpackage

// File: rtl/regfile_sb_if.sv
// Writeback / issue / read bundle between the pipeline and the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic                           i_wb_valid;
    logic [AW-1:0]                  i_wb_index;
    logic [XLEN-1:0]                i_wb_data;
    logic                           i_issue_valid;
    logic [AW-1:0]                  i_issue_index;
    logic [NREAD-1:0][AW-1:0]       i_rd_index;
    logic [NREAD-1:0][XLEN-1:0]     o_rd_data;
    logic [NREAD-1:0]               o_rd_busy;
    logic [CW-1:0]                  o_busy_count;

    modport master (
        output i_wb_valid, i_wb_index, i_wb_data,
        output i_issue_valid, i_issue_index, i_rd_index,
        input  o_rd_data, o_rd_busy, o_busy_count
    );

    modport slave (
        input  i_wb_valid, i_wb_index, i_wb_data,
        input  i_issue_valid, i_issue_index, i_rd_index,
        output o_rd_data, o_rd_busy, o_busy_count
    );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-destination tracker: one busy bit per register plus a running count.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_index,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_index,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_count
);
    logic             set_en;
    logic             clr_en;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        set_en = issue_valid && (issue_index != '0);
        clr_en = wb_valid && (wb_index != '0);
        // Count only real transitions: WAW re-issue and writeback-to-idle are no-ops,
        // and a same-index issue cancels the clear.
        inc = set_en && !busy[issue_index];
        dec = clr_en && busy[wb_index] && !(set_en && (issue_index == wb_index));
        busy_nxt = busy;
        if (clr_en) busy_nxt[wb_index] = 1'b0;
        if (set_en) busy_nxt[issue_index] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= busy_count + CW'(inc) - CW'(dec);
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with zero-latency bypassed reads and a busy scoreboard; x0 is hardwired to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = AW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    regfile_sb_if.slave  bus
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [CW-1:0]    busy_count;
    logic [NREAD-1:0] wb_fwd;

    regfile_sb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .wb_valid    (bus.i_wb_valid),
        .wb_index    (bus.i_wb_index),
        .issue_valid (bus.i_issue_valid),
        .issue_index (bus.i_issue_index),
        .busy        (busy),
        .busy_count  (busy_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.i_wb_valid && (bus.i_wb_index != '0)) begin
            regs[bus.i_wb_index] <= bus.i_wb_data;
        end
    end

    always_comb begin
        wb_fwd        = '0;
        bus.o_rd_data = '0;
        bus.o_rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            wb_fwd[p] = bus.i_wb_valid && (bus.i_wb_index == bus.i_rd_index[p]);
            if (bus.i_rd_index[p] != '0) begin
                bus.o_rd_data[p] = wb_fwd[p] ? bus.i_wb_data : regs[bus.i_rd_index[p]];
                // A writeback landing this cycle satisfies the operand already.
                bus.o_rd_busy[p] = busy[bus.i_rd_index[p]] && !wb_fwd[p];
            end
        end
    end

    assign bus.o_busy_count = busy_count;
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count, power of two, minimum 4.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of independent read ports, minimum 1.
REQ-004 SHALL derive AW = log2(NREGS) as index width; CW = AW+1 as count width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port i_wb_valid, input, 1, writeback strobe.
REQ-008 SHALL have port i_wb_index, input, AW, writeback destination.
REQ-009 SHALL have port i_wb_data, input, XLEN, writeback value.
REQ-010 SHALL have port i_issue_valid, input, 1, instruction issue strobe that reserves a destination.
REQ-011 SHALL have port i_issue_index, input, AW, destination being reserved.
REQ-012 SHALL have port i_rd_index, input, NREAD x AW, per-port read index.
REQ-013 SHALL have port o_rd_data, output, NREAD x XLEN, per-port read data.
REQ-014 SHALL have port o_rd_busy, output, NREAD, per-port flag: operand still pending.
REQ-015 SHALL have port o_busy_count, output, CW, number of pending registers, registered.

Function
REQ-016 SHALL store NREGS-1 registers; index 0 reads 0, ignores writes and issues, and is never busy.
REQ-017 SHALL commit i_wb_data to i_wb_index at the rising edge when i_wb_valid=1 and i_wb_index!=0.
REQ-018 SHALL drive o_rd_data combinationally, zero latency, with write bypass: if i_wb_valid=1, i_wb_index=i_rd_index[p]!=0, return i_wb_data.
REQ-019 SHALL set busy[i] at the edge when i_issue_valid=1 and i_issue_index=i!=0.
REQ-020 SHALL clear busy[i] at the edge when i_wb_valid=1 and i_wb_index=i.
REQ-021 SHALL, when issue and writeback target the same index in one cycle, leave busy=1 (new issue wins) and still commit the data.
REQ-022 SHALL drive o_rd_busy[p] = busy[idx] AND NOT (same-cycle writeback to idx); a same-cycle issue to idx does not affect it.
REQ-023 SHALL treat issue to an already-busy register as a WAW reservation: busy stays 1, count unchanged.
REQ-024 SHALL treat writeback to a non-busy register as a plain write: data committed, count unchanged.
REQ-025 SHALL update o_busy_count each edge by +1 for a set, -1 for a clear, 0 for both or neither; it equals popcount(busy) after every edge and never exceeds NREGS-1.
REQ-026 SHALL allow every read port to address any index, including identical indices, without interaction.

Reset
REQ-027 SHALL, on i_rst_n=0, asynchronously clear all registers to 0, all busy bits to 0 and o_busy_count to 0, regardless of the clock.
REQ-028 SHALL ignore i_wb_valid and i_issue_valid while i_rst_n=0; state mid-operation is discarded.
REQ-029 SHALL resume normal updates on the first rising edge after i_rst_n deasserts.

Structure
REQ-030 SHALL place defaults XLEN_DEFAULT=32 and NREGS_DEFAULT=32 in the shared package regfile_pkg.
REQ-031 SHALL place the busy-vector and count logic in one sub-module, regfile_sb_scoreboard; data storage and bypass stay in regfile_sb.

Verification
REQ-032 SHALL test reset-and-read: assert reset, then deassert -> all o_rd_data=0, all o_rd_busy=0, o_busy_count=0.
REQ-033 SHALL test bypass: wb idx 5 = 0xDEADBEEF with rd_index[0]=5 in the same cycle -> o_rd_data[0]=0xDEADBEEF that cycle and thereafter.
REQ-034 SHALL test x0: wb idx 0 = 0xFFFFFFFF plus issue idx 0 -> reads 0, busy 0, count 0.
REQ-035 SHALL test scoreboard: issue 3, 7, 3 on successive cycles -> count 1, 2, 2; wb 7 -> count 1, o_rd_busy for 7 drops in the wb cycle.
REQ-036 SHALL test a simultaneous event: busy reg 9, issue 9 and wb 9 = 0x12 in the same cycle -> busy stays 1, count unchanged, data 0x12.
REQ-037 SHALL test mid-operation reset: 4 regs busy, assert reset between edges -> count 0 immediately, data 0, no updates until deassertion.
